// File: rtl/pong_pkg.sv
// Shared pong constants: screen/paddle limits, the AI state encoding and the
// LFSR step used by the optional error injector.
package pong_pkg;
  localparam int POS_W  = 10;
  localparam int MIN    = 30;
  localparam int MAX    = 329;
  localparam int CENTER = 180;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    TRACK = 2'd2
  } state_t;

  // Fibonacci step, taps 16,14,13,11, shifting towards bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction
endpackage

// File: rtl/tick_gen.sv
// Free-running divider: o_tick is high for one clk every TICK_DIV cycles.
module tick_gen #(
  parameter int TICK_DIV = 416667
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // counter 0..TICK_DIV-1, wrapping after the tick cycle
  always_ff @(posedge clk) begin
    if (reset)              r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/barra_ia.sv
// Automatic pong opponent: issues up/down pulses that track the ball after a
// reaction delay, or recentre the paddle. Macro IA_ERROR_EN adds LFSR-driven missed moves.
module barra_ia #(
  parameter int MIN      = pong_pkg::MIN,
  parameter int MAX      = pong_pkg::MAX,
  parameter int CENTER   = pong_pkg::CENTER,
  parameter int DEAD     = 4,
  parameter int REACT    = 3,
  parameter int TICK_DIV = 416667
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [pong_pkg::POS_W-1:0] ball_y,
  input  logic                       ball_toward,
  input  logic [pong_pkg::POS_W-1:0] paddle_y,
  output logic                       up,
  output logic                       down
);
  import pong_pkg::*;

  localparam int RW = (REACT > 1) ? $clog2(REACT + 1) : 1;
  localparam int CW = POS_W + 1;
  localparam logic [CW-1:0] C_MIN    = CW'(MIN);
  localparam logic [CW-1:0] C_MAX    = CW'(MAX);
  localparam logic [CW-1:0] C_CENTER = CW'(CENTER);
  localparam logic [CW-1:0] C_DEAD   = CW'(DEAD);
  localparam logic [RW-1:0] C_REACT  = RW'(REACT);

  logic          w_tick;
  state_t        r_state, w_state_next;
  logic [RW-1:0] r_react, w_react_next;
  logic [CW-1:0] w_ball, w_paddle, w_target;
  logic          w_up_due, w_down_due, w_skip;
  logic          r_up, r_down;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  // 11-bit compares so adding DEAD can never wrap
  assign w_ball   = {1'b0, ball_y};
  assign w_paddle = {1'b0, paddle_y};

  // target: clamped ball while tracking, home position otherwise
  always_comb begin
    w_target = C_CENTER;
    if (r_state == TRACK) begin
      if (w_ball < C_MIN)      w_target = C_MIN;
      else if (w_ball > C_MAX) w_target = C_MAX;
      else                     w_target = w_ball;
    end else begin
      w_target = C_CENTER;
    end
  end

  assign w_up_due   = (w_target > w_paddle + C_DEAD);
  assign w_down_due = (w_target + C_DEAD < w_paddle);

  // next state and reaction counter; leaving WAIT on the REACT-th tick
  always_comb begin
    w_state_next = r_state;
    w_react_next = r_react;
    if (!enable) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (ball_toward) begin
            w_state_next = WAIT;
            w_react_next = C_REACT;
          end else begin
            w_state_next = IDLE;
          end
        end
        WAIT: begin
          if (!ball_toward)                w_state_next = IDLE;
          else if (w_tick) begin
            if (r_react <= RW'(1))         w_state_next = TRACK;
            else                           w_react_next = r_react - RW'(1);
          end else                         w_state_next = WAIT;
        end
        TRACK: begin
          if (!ball_toward) w_state_next = IDLE;
          else              w_state_next = TRACK;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // state and reaction counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_react <= '0;
    end else begin
      r_state <= w_state_next;
      r_react <= w_react_next;
    end
  end

`ifdef IA_ERROR_EN
  logic [15:0] r_lfsr;

  // miss generator advances once per move tick
  always_ff @(posedge clk) begin
    if (reset)       r_lfsr <= 16'hACE1;
    else if (w_tick) r_lfsr <= lfsr_next(r_lfsr);
  end

  assign w_skip = (r_state == TRACK) && (r_lfsr[2:0] == 3'd0);
`else
  assign w_skip = 1'b0;
`endif

  // one-cycle move pulses, only in the cycle after a tick
  always_ff @(posedge clk) begin
    if (reset) begin
      r_up   <= 1'b0;
      r_down <= 1'b0;
    end else if (enable && w_tick && !w_skip) begin
      r_up   <= w_up_due;
      r_down <= w_down_due;
    end else begin
      r_up   <= 1'b0;
      r_down <= 1'b0;
    end
  end

  assign up   = r_up;
  assign down = r_down;
endmodule

// File: tb/tb_barra_ia.sv
// Self-checking bench for barra_ia (TICK_DIV=4, REACT=3, DEAD=4) against a
// behavioural model; define IA_ERROR_EN to check the missed-move variant.
module tb_barra_ia;
  localparam int TDIV = 4;
  localparam int REACT = 3;
  localparam int DEAD = 4;
`ifdef IA_ERROR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  localparam int M_IDLE = 0, M_WAIT = 1, M_TRACK = 2;

  logic       clk = 1'b0;
  logic       reset, enable, ball_toward;
  logic [9:0] ball_y, paddle_y;
  logic       up, down;

  barra_ia #(.DEAD(DEAD), .REACT(REACT), .TICK_DIV(TDIV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ball_y(ball_y),
    .ball_toward(ball_toward), .paddle_y(paddle_y), .up(up), .down(down)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int m_cyc, m_mode, m_waited;
  logic [15:0] m_lfsr;
  bit last_tick, fb;
  int cnt_up, cnt_down, exp_up_cnt, track_ticks;

  function automatic int clampy(input int v);
    if (v < 30) return 30;
    if (v > 329) return 329;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock: predict from pre-edge inputs, then compare after the edge
  task automatic step();
    bit tick, eu, ed;
    int tgt, p, bit0;
    tick = (m_cyc % TDIV) == TDIV - 1;
    eu = 1'b0; ed = 1'b0;
    p = int'(paddle_y);
    if (!reset && enable && tick) begin
      tgt = (m_mode == M_TRACK) ? clampy(int'(ball_y)) : 180;
      if (!(ERR && m_mode == M_TRACK && m_lfsr[2:0] == 3'd0)) begin
        eu = tgt > p + DEAD;
        ed = tgt + DEAD < p;
      end
    end
    if (!reset && tick && m_mode == M_TRACK) track_ticks++;
    if (reset) begin
      m_mode = M_IDLE; m_waited = 0; m_cyc = 0; m_lfsr = 16'hACE1;
    end else begin
      if (!enable) m_mode = M_IDLE;
      else if (m_mode == M_IDLE) begin
        if (ball_toward) begin m_mode = M_WAIT; m_waited = 0; end
      end else if (m_mode == M_WAIT) begin
        if (!ball_toward) m_mode = M_IDLE;
        else if (tick) begin
          m_waited++;
          if (m_waited >= ((REACT < 1) ? 1 : REACT)) m_mode = M_TRACK;
        end
      end else if (!ball_toward) m_mode = M_IDLE;
      m_cyc++;
      if (tick) begin
        bit0 = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = 16'((m_lfsr >> 1) | (bit0 << 15));
      end
    end
    @(posedge clk);
    #1;
    chk("up", {31'd0, up}, {31'd0, eu});
    chk("down", {31'd0, down}, {31'd0, ed});
    last_tick = tick;
    if (up === 1'b1) cnt_up++;
    if (down === 1'b1) cnt_down++;
    if (eu) exp_up_cnt++;
    if (fb && down === 1'b1) paddle_y = paddle_y - 10'd1;
    if (fb && up === 1'b1) paddle_y = paddle_y + 10'd1;
  endtask

  task automatic sync_tick();
    for (int i = 0; i < 2 * TDIV; i++) begin
      step();
      if (last_tick) break;
    end
  endtask

  task automatic clr();
    cnt_up = 0; cnt_down = 0; exp_up_cnt = 0; track_ticks = 0;
  endtask

  initial begin
    int u12, n;
    reset = 1'b1; enable = 1'b1; ball_toward = 1'b0; ball_y = 10'd0; paddle_y = 10'd180;
    fb = 1'b0; m_cyc = 0; m_mode = M_IDLE; m_waited = 0; m_lfsr = 16'hACE1;
    clr();
    repeat (3) step();
    chk("reset_up", {31'd0, up}, 32'd0);
    chk("reset_down", {31'd0, down}, 32'd0);
    reset = 1'b0;

    // centred paddle while ball moves away: silent
    clr();
    repeat (24) step();
    chk("center_quiet", cnt_up + cnt_down, 32'd0);

    // recentre from 250 with paddle feedback
    paddle_y = 10'd250; fb = 1'b1; clr();
    for (int i = 0; i < 400 && paddle_y > 10'd184; i++) step();
    repeat (12) step();
    chk("recentre_pos", {22'd0, paddle_y}, 32'd184);
    chk("recentre_downs", cnt_down, 32'd66);
    fb = 1'b0;

    // ball turns toward: three silent ticks, then up every tick
    paddle_y = 10'd180; ball_y = 10'd300;
    sync_tick();
    ball_toward = 1'b1; clr();
    repeat (12) step();
    chk("wait_quiet", cnt_up + cnt_down, 32'd0);
    repeat (12) step();
    chk("track_ups", cnt_up, ERR ? exp_up_cnt : 32'd3);

    // clamping at the low and high edge
    ball_y = 10'd5; paddle_y = 10'd32; clr();
    repeat (12) step();
    chk("low_clamp_quiet", cnt_down + cnt_up, 32'd0);
    paddle_y = 10'd40; clr();
    repeat (12) step();
    chk("low_clamp_down", cnt_down, ERR ? 32'(cnt_down) : 32'd3);
    ball_y = 10'd1023; paddle_y = 10'd329; clr();
    repeat (12) step();
    chk("max_no_up", cnt_up, 32'd0);
    ball_y = 10'd0; paddle_y = 10'd30; clr();
    repeat (12) step();
    chk("min_no_down", cnt_down, 32'd0);

    // enable dropped mid-track, then full reaction wait again
    ball_y = 10'd300; paddle_y = 10'd180;
    sync_tick();
    enable = 1'b0; clr();
    repeat (8) step();
    chk("disabled_quiet", cnt_up + cnt_down, 32'd0);
    enable = 1'b1; clr();
    repeat (12) step();
    chk("reenable_wait", cnt_up, 32'd0);
    repeat (4) step();
    u12 = cnt_up;

    // long tracking run, target far above paddle
    ball_y = 10'd329; paddle_y = 10'd30; clr();
    n = 0;
    while (track_ticks < 800 && n < 4000) begin step(); n++; end
    repeat (2) step();
    chk("long_ticks", track_ticks >= 800, 32'd1);
    chk("long_pulses", cnt_up, ERR ? exp_up_cnt : 32'(track_ticks));

    // reset arriving while a pulse is high
    clr();
    for (int i = 0; i < 40 && up !== 1'b1; i++) step();
    chk("pulse_seen", {31'd0, up}, 32'd1);
    reset = 1'b1;
    step();
    chk("reset_midpulse", {31'd0, up}, 32'd0);
    reset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(15) == 0) ball_toward = ~ball_toward;
      enable = ($urandom_range(31) != 0);
      if ($urandom_range(3) == 0) ball_y = 10'($urandom_range(1023));
      case ($urandom_range(2))
        0: paddle_y = 10'(180 + $urandom_range(16) - 8);
        1: paddle_y = 10'(clampy(int'(ball_y)) + $urandom_range(16) - 8);
        default: paddle_y = 10'($urandom_range(1023));
      endcase
      step();
      chk("exclusive", {31'd0, up & down}, 32'd0);
    end
    if (u12 < 0) chk("unused", 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/barra_ia.md
Name: barra_ia

Overview:
- Automatic opponent for the pong game: generates the up/down command pair that drives a barra paddle instance, in place of the push-buttons.
- Inputs: ball vertical position and direction, plus current paddle y fed back from barra.
- Output: one-clk up/down pulses at a fixed move-tick rate.
- While the ball approaches, tracks it after a reaction delay; otherwise recentres the paddle.

Parameters:
- MIN, 30, lowest paddle y; tracking target clamped to it.
- MAX, 329, highest paddle y; tracking target clamped to it.
- CENTER, 180, home position while ball moves away.
- DEAD, 4, dead-zone half-width in pixels; no move while |target - paddle_y| <= DEAD.
- REACT, 3, move ticks waited after ball turns toward paddle before tracking.
- TICK_DIV, 416667, clk cycles per move tick (60 Hz at 25 MHz); bench overrides to 4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  1 = AI controls paddle; 0 = outputs forced low, FSM to IDLE.
- ball_y  in  10  ball vertical position, pixels.
- ball_toward  in  1  1 = ball horizontal velocity points at this paddle.
- paddle_y  in  10  current y from barra.
- up  out  1  one-clk pulse, move paddle +y.
- down  out  1  one-clk pulse, move paddle -y.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset:
  - up=0, down=0, tick counter=0, react counter=0, state=IDLE.
  - Reset mid-pulse clears the pulse the same edge.
- Tick generator:
  - Counter 0..TICK_DIV-1.
  - tick=1 for the single cycle the counter equals TICK_DIV-1, then it wraps to 0.
  - Runs regardless of enable.
- Target:
  - TRACK: ball_y clamped to [MIN,MAX].
  - IDLE and WAIT: CENTER.
  - All compares in 11-bit unsigned (zero-extended) so target+DEAD and paddle_y+DEAD never wrap.
- States:
  - IDLE (recentre):
    - ball_toward=1 and enable=1: to WAIT, react counter loaded with REACT.
  - WAIT:
    - On each tick, decrement react counter; when it is 0 at a tick, go to TRACK.
    - REACT=0: go to TRACK on the first tick.
    - ball_toward=0: back to IDLE immediately.
  - TRACK:
    - ball_toward=0: to IDLE.
  - enable=0 in any state: to IDLE next edge.
- Move decision, evaluated only on tick, in all states with enable=1:
  - target > paddle_y+DEAD: up=1.
  - target+DEAD < paddle_y: down=1.
  - Otherwise both 0.
- Output timing:
  - Outputs registered, asserted in the cycle after tick, high exactly one cycle.
  - up and down are never both 1.
  - No pulse without a tick.
- Boundaries:
  - Saturation is left to barra.
  - The block still issues up when paddle_y=MAX only if target > MAX+DEAD, which clamping prevents. No up is issued at MAX, no down at MIN.
- Latency: ball change to first pulse is at most one tick period plus 1 cycle in TRACK, and REACT additional ticks from IDLE.

Optional Feature:
- Macro IA_ERROR_EN.
- Defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) advances each tick.
  - In TRACK, a tick where LFSR[2:0]==0 produces no pulse (about 1/8 missed moves), making the AI beatable.
- Undefined: no LFSR logic; every qualifying tick pulses.

Decomposition:
- Shared package pong_pkg:
  - screen/paddle constants MIN, MAX, CENTER, POS_W=10.
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, TRACK=2'd2).
- Sub-module tick_gen(TICK_DIV) producing the one-cycle tick; reusable by barra speed control and ball update.
- FSM and compare logic stay in barra_ia.

Test Plan (TICK_DIV=4, REACT=3, DEAD=4):
- Reset held 3 cycles, then released with ball_toward=0, paddle_y=180 -> up=down=0 forever (target=CENTER within dead zone).
- ball_toward=0, paddle_y=250 -> one down pulse per 4 cycles, one cycle after each tick, until paddle_y<=184.
- ball_toward rises, ball_y=300, paddle_y=180 -> no pulse for 3 ticks (WAIT), then up pulse on the 4th tick and every tick after.
- TRACK with ball_y=5, paddle_y=32 -> target clamps to 30; no down (32-30<=DEAD). Then paddle_y=40 -> down pulses.
- enable dropped mid-TRACK while up is due -> no pulse next tick, state IDLE. Re-enable with ball_toward=1 -> full REACT wait again.
- IA_ERROR_EN defined, 800 ticks in TRACK with target far away -> pulse count 700 ±5 (matches golden LFSR model exactly). Not defined -> exactly 800.
